cont_read_sched: RTL and testbench

CONT_READ_SCHED -- requirements
Module: cont_read_sched

---
 rtl/cont_read_sched.sv | 174 +++++++++++++++++
 tb/tb_cont_read_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cont_read_sched.sv
// -----------------------------------------------------------------------------
// cont_read_sched
//
// Reads counter values out of a four-entry counter bank on behalf of a host.
// The host pulses start together with a mode selection:
//   sweep = 1 : read indices 0, 1, 2, 3 in order, one per cycle when the bank
//               is ready (back-to-back captures).
//   sweep = 0 : read the single counter selected by idx_in.
// The bank answers a request combinationally through valid_out. If the bank
// stays non-valid for TIMEOUT consecutive request cycles on one index, the
// transaction is aborted with an err strobe. Any sweep indices that were not
// read yet are dropped.
//
// Parameters
//   CBITS   : counter data width (must match the counter bank)
//   TIMEOUT : consecutive non-valid request cycles that abort (2..15)
//
// Ports
//   clk         : single clock, rising edge
//   reset       : asynchronous, active-low reset
//   start       : host request pulse (ignored while a transaction runs)
//   sweep       : mode select, sampled with start
//   idx_in      : counter index for single mode, sampled with start
//   counter_out : read data from the bank
//   valid_out   : bank valid, responds to req in the same cycle
//   idx         : counter index driven to the bank
//   req         : read request driven to the bank
//   data_out    : last captured counter value (holds between captures)
//   data_idx    : index belonging to data_out
//   data_valid  : one-cycle strobe qualifying data_out / data_idx
//   busy        : transaction in progress
//   done        : one-cycle end-of-transaction strobe
//   err         : one-cycle timeout strobe, coincident with done
// -----------------------------------------------------------------------------
module cont_read_sched #(
    parameter int CBITS   = 7,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sweep,
    input  logic [1:0]       idx_in,
    input  logic [CBITS-1:0] counter_out,
    input  logic             valid_out,
    output logic [1:0]       idx,
    output logic             req,
    output logic [CBITS-1:0] data_out,
    output logic [1:0]       data_idx,
    output logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // One extra bit over what TIMEOUT-1 needs, so the counter has headroom
    // and can never wrap even if the compare were ever widened.
    localparam int WCW = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [1:0]     IDX_LAST  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [1:0]       cur_idx_q,    cur_idx_d;
    logic             sweep_q,      sweep_d;
    logic [WCW-1:0]   wait_cnt_q,   wait_cnt_d;
    logic [CBITS-1:0] data_out_q,   data_out_d;
    logic [1:0]       data_idx_q,   data_idx_d;
    logic             data_valid_q, data_valid_d;
    // Remembers that the transition into S_DONE was caused by a timeout.
    logic             err_q,        err_d;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cur_idx_q    <= 2'd0;
            sweep_q      <= 1'b0;
            wait_cnt_q   <= '0;
            data_out_q   <= '0;
            data_idx_q   <= 2'd0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            sweep_q      <= sweep_d;
            wait_cnt_q   <= wait_cnt_d;
            data_out_q   <= data_out_d;
            data_idx_q   <= data_idx_d;
            data_valid_q <= data_valid_d;
            err_q        <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        sweep_d      = sweep_q;
        wait_cnt_d   = wait_cnt_q;
        data_out_d   = data_out_q;
        data_idx_d   = data_idx_q;
        // Strobes default low so they last exactly one cycle.
        data_valid_d = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sweep_d    = sweep;
                    cur_idx_d  = sweep ? 2'd0 : idx_in;
                    wait_cnt_d = '0;
                    state_d    = S_READ;
                end
            end

            S_READ: begin
                if (valid_out) begin
                    data_out_d   = counter_out;
                    data_idx_d   = cur_idx_q;
                    data_valid_d = 1'b1;
                    // Timeout is measured per index: every capture restarts it.
                    wait_cnt_d   = '0;
                    if (sweep_q && (cur_idx_q != IDX_LAST)) begin
                        cur_idx_d = cur_idx_q + 2'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // This is the TIMEOUT-th miss on the current index.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: handshake/status decoded from state so req rises the cycle
    // after start and everything drops to zero the moment reset asserts.
    // -------------------------------------------------------------------------
    always_comb begin
        req  = (state_q == S_READ);
        busy = (state_q == S_READ);
        idx  = (state_q == S_READ) ? cur_idx_q : 2'd0;
        done = (state_q == S_DONE);
        err  = (state_q == S_DONE) && err_q;
    end

    assign data_out   = data_out_q;
    assign data_idx   = data_idx_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_cont_read_sched.sv
// -----------------------------------------------------------------------------
// tb_cont_read_sched
//
// Directed bench for cont_read_sched. A small behavioural counter bank holds
// {5, 9, 3, 7}; its valid answers req combinationally, gated by bank_ready
// which each scenario steers cycle by cycle. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cont_read_sched;

    localparam int CBITS   = 7;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             sweep;
    logic [1:0]       idx_in;
    logic [CBITS-1:0] counter_out;
    logic             valid_out;
    logic [1:0]       idx;
    logic             req;
    logic [CBITS-1:0] data_out;
    logic [1:0]       data_idx;
    logic             data_valid;
    logic             busy;
    logic             done;
    logic             err;

    logic             bank_ready;
    logic [CBITS-1:0] bank_mem [4];

    int checks = 0;
    int errors = 0;

    // {req, busy, done, err, data_valid}
    logic [4:0] flags;
    assign flags = {req, busy, done, err, data_valid};

    always #5 clk = ~clk;

    assign counter_out = bank_mem[idx];
    assign valid_out   = req & bank_ready;

    cont_read_sched #(
        .CBITS   (CBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sweep       (sweep),
        .idx_in      (idx_in),
        .counter_out (counter_out),
        .valid_out   (valid_out),
        .idx         (idx),
        .req         (req),
        .data_out    (data_out),
        .data_idx    (data_idx),
        .data_valid  (data_valid),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; sweep = 1'b0; idx_in = 2'd0; bank_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (flags !== 5'b00000 || idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags: flags=%b idx=%0d, required flags=00000 idx=0", flags, idx);
        end
        checks++;
        if (data_out !== 7'd0 || data_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: data_out=%0d data_idx=%0d, required 0/0", data_out, data_idx);
        end
        reset = 1'b1;
        $display("test_reset: reset held and released");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        start = 1'b1; sweep = 1'b0; idx_in = 2'd2; bank_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (flags !== 5'b11000 || idx !== 2'd2) begin
            errors++;
            $display("FAIL single_req: flags=%b idx=%0d, required flags=11000 idx=2", flags, idx);
        end
        @(negedge clk);
        checks++;
        if (flags !== 5'b00101 || data_out !== 7'd3 || data_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_capture: flags=%b data=%0d didx=%0d, required flags=00101 data=3 didx=2",
                     flags, data_out, data_idx);
        end
        @(negedge clk);
        checks++;
        if (flags !== 5'b00000 || data_out !== 7'd3 || data_idx !== 2'd2) begin
            errors++;
            $display("FAIL single_hold: flags=%b data=%0d didx=%0d, required flags=00000 data=3 didx=2",
                     flags, data_out, data_idx);
        end
        $display("test_single: idx 2 read");
    endtask

    // ------------------------------------------------------------------
    // Sweep with a stray start pulse in the middle, which must be neither
    // acted upon nor queued.
    task automatic test_sweep();
        logic [CBITS-1:0] exp_val [4];
        exp_val[0] = 7'd5; exp_val[1] = 7'd9; exp_val[2] = 7'd3; exp_val[3] = 7'd7;
        start = 1'b1; sweep = 1'b1; idx_in = 2'd2; bank_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i == 1);
            sweep = (i == 1) ? 1'b0 : 1'b1;
            idx_in = 2'd3;
            checks++;
            if (flags !== ((i == 0) ? 5'b11000 : 5'b11001) || idx !== 2'(i)) begin
                errors++;
                $display("FAIL sweep_req%0d: flags=%b idx=%0d, required flags=%b idx=%0d",
                         i, flags, idx, (i == 0) ? 5'b11000 : 5'b11001, i);
            end
            if (i > 0) begin
                checks++;
                if (data_out !== exp_val[i-1] || data_idx !== 2'(i - 1)) begin
                    errors++;
                    $display("FAIL sweep_data%0d: data=%0d didx=%0d, required data=%0d didx=%0d",
                             i - 1, data_out, data_idx, exp_val[i-1], i - 1);
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (flags !== 5'b00101 || data_out !== 7'd7 || data_idx !== 2'd3) begin
            errors++;
            $display("FAIL sweep_last: flags=%b data=%0d didx=%0d, required flags=00101 data=7 didx=3",
                     flags, data_out, data_idx);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("FAIL sweep_no_queue%0d: flags=%b, required 00000", k, flags);
            end
        end
        $display("test_sweep: 4 counters swept");
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        start = 1'b1; sweep = 1'b1; idx_in = 2'd0; bank_ready = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (flags !== 5'b11000 || idx !== 2'd0) begin
                errors++;
                $display("FAIL timeout_wait%0d: flags=%b idx=%0d, required flags=11000 idx=0", k, flags, idx);
            end
        end
        @(negedge clk);
        checks++;
        if (flags !== 5'b00110) begin
            errors++;
            $display("FAIL timeout_strobe: flags=%b, required 00110", flags);
        end
        checks++;
        if (data_out !== 7'd7 || data_idx !== 2'd3) begin
            errors++;
            $display("FAIL timeout_data_hold: data=%0d didx=%0d, required 7/3", data_out, data_idx);
        end
        @(negedge clk);
        checks++;
        if (flags !== 5'b00000) begin
            errors++;
            $display("FAIL timeout_after: flags=%b, required 00000", flags);
        end
        $display("test_timeout: aborted after %0d cycles", TIMEOUT);
    endtask

    // ------------------------------------------------------------------
    task automatic test_late_valid();
        start = 1'b1; sweep = 1'b0; idx_in = 2'd1; bank_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (flags !== 5'b11000 || idx !== 2'd1) begin
                errors++;
                $display("FAIL late_wait%0d: flags=%b idx=%0d, required flags=11000 idx=1", k, flags, idx);
            end
            if (k == 4) bank_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (flags !== 5'b00101 || data_out !== 7'd9 || data_idx !== 2'd1) begin
            errors++;
            $display("FAIL late_capture: flags=%b data=%0d didx=%0d, required flags=00101 data=9 didx=1",
                     flags, data_out, data_idx);
        end
        @(negedge clk);
        $display("test_late_valid: idx 1 read after 3 stalls");
    endtask

    // ------------------------------------------------------------------
    task automatic test_sweep_stall();
        logic [1:0]       exp_idx [8];
        logic [4:0]       exp_flg [8];
        logic [CBITS-1:0] exp_dat [8];
        exp_idx = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_flg = '{5'b11000, 5'b11001, 5'b11000, 5'b11000, 5'b11000, 5'b11001, 5'b11001, 5'b00101};
        exp_dat = '{7'd0, 7'd5, 7'd5, 7'd5, 7'd5, 7'd9, 7'd3, 7'd7};
        start = 1'b1; sweep = 1'b1; idx_in = 2'd0; bank_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (flags !== exp_flg[n] || idx !== exp_idx[n]) begin
                errors++;
                $display("FAIL stall_cyc%0d: flags=%b idx=%0d, required flags=%b idx=%0d",
                         n, flags, idx, exp_flg[n], exp_idx[n]);
            end
            if (exp_flg[n][0]) begin
                checks++;
                if (data_out !== exp_dat[n]) begin
                    errors++;
                    $display("FAIL stall_data%0d: data=%0d, required %0d", n, data_out, exp_dat[n]);
                end
            end
            // Bank goes non-valid for the first three cycles spent on idx 1.
            bank_ready = !(n >= 1 && n <= 3);
        end
        @(negedge clk);
        $display("test_sweep_stall: sweep completed after stall on idx 1");
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        start = 1'b1; sweep = 1'b1; idx_in = 2'd0; bank_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (flags !== 5'b11001 || idx !== 2'd2) begin
            errors++;
            $display("FAIL midrst_pre: flags=%b idx=%0d, required flags=11001 idx=2", flags, idx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (flags !== 5'b00000 || idx !== 2'd0 || data_out !== 7'd0 || data_idx !== 2'd0) begin
            errors++;
            $display("FAIL midrst_async: flags=%b idx=%0d data=%0d didx=%0d, required all 0",
                     flags, idx, data_out, data_idx);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (flags !== 5'b00000) begin
                errors++;
                $display("FAIL midrst_no_done%0d: flags=%b, required 00000", k, flags);
            end
        end
        $display("test_mid_reset: sweep aborted by reset at idx 2");
    endtask

    // ------------------------------------------------------------------
    initial begin
        bank_mem[0] = 7'd5;
        bank_mem[1] = 7'd9;
        bank_mem[2] = 7'd3;
        bank_mem[3] = 7'd7;
        test_reset();
        test_single();
        test_sweep();
        test_timeout();
        test_late_valid();
        test_sweep_stall();
        test_mid_reset();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
